// File: rtl/mc_control.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Strobes come from the registered state; the instruction fields are captured in DECODE.
module mc_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] inst,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [1:0]  mem_val,
    output logic        ir_wen,
    output logic        pc_wen,
    output logic        rf_wen,
    output logic [2:0]  pc_sel,
    output logic [4:0]  alufun,
    output logic        op1sel,
    output logic [1:0]  op2sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        trap
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJal} cls_e;

    localparam logic [4:0] AluAdd   = 5'd0;
    localparam logic [4:0] AluSub   = 5'd1;
    localparam logic [4:0] AluSll   = 5'd2;
    localparam logic [4:0] AluSlt   = 5'd3;
    localparam logic [4:0] AluXor   = 5'd4;
    localparam logic [4:0] AluOr    = 5'd5;
    localparam logic [4:0] AluAnd   = 5'd6;
    localparam logic [4:0] AluCopy2 = 5'd7;

    localparam logic       Op1Rs1  = 1'b0;
    localparam logic       Op1Pc   = 1'b1;
    localparam logic [1:0] Op2Rs2  = 2'd0;
    localparam logic [1:0] Op2ImmI = 2'd1;
    localparam logic [1:0] Op2ImmS = 2'd2;
    localparam logic [1:0] Op2ImmU = 2'd3;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc4 = 2'd2;

    localparam logic [2:0] PcPlus4 = 3'd0;
    localparam logic [2:0] PcJal   = 3'd2;
    localparam logic [2:0] PcBr    = 3'd3;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    cls_e              cls_q, cls_d, dec_cls;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        alufun_q, alufun_d, dec_alufun;
    logic              op1sel_q, op1sel_d, dec_op1;
    logic [1:0]        op2sel_q, op2sel_d, dec_op2;
    logic              dec_legal;
    logic              br_taken;
    logic              timed_out;
    logic [1:0]        wb_cls;
    logic              unused_inst;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign unused_inst = ^inst[24:15];

    always_comb begin
        dec_legal  = 1'b0;
        dec_cls    = ClsAlu;
        dec_alufun = AluAdd;
        dec_op1    = Op1Rs1;
        dec_op2    = Op2Rs2;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alufun = AluAdd;
                        3'b001:  dec_alufun = AluSll;
                        3'b100:  dec_alufun = AluXor;
                        3'b110:  dec_alufun = AluOr;
                        default: dec_legal  = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_alufun = AluSub;
                end
            end
            7'b0010011: begin
                dec_legal = 1'b1;
                dec_op2   = Op2ImmI;
                case (funct3)
                    3'b000: dec_alufun = AluAdd;
                    3'b010: dec_alufun = AluSlt;
                    3'b110: dec_alufun = AluOr;
                    3'b111: dec_alufun = AluAnd;
                    3'b001: begin
                        dec_alufun = AluSll;
                        dec_legal  = (funct7 == 7'b0000000);
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0110111: begin
                dec_legal  = 1'b1;
                dec_op2    = Op2ImmU;
                dec_alufun = AluCopy2;
            end
            7'b0000011: begin
                dec_legal = (funct3 < 3'd3);
                dec_cls   = ClsLoad;
                dec_op2   = Op2ImmI;
            end
            7'b0100011: begin
                dec_legal = (funct3 < 3'd3);
                dec_cls   = ClsStore;
                dec_op2   = Op2ImmS;
            end
            7'b1100011: begin
                dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec_cls    = ClsBranch;
                dec_alufun = AluSub;
            end
            7'b1101111: begin
                dec_legal = 1'b1;
                dec_cls   = ClsJal;
                dec_op1   = Op1Pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3_q)
            3'b000:  br_taken = (rs1 == rs2);
            3'b001:  br_taken = (rs1 != rs2);
            3'b100:  br_taken = ($signed(rs1) < $signed(rs2));
            3'b101:  br_taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  br_taken = (rs1 < rs2);
            3'b111:  br_taken = (rs1 >= rs2);
            default: br_taken = 1'b0;
        endcase
    end

    assign timed_out = (cnt_q == TO_W'(MEM_TIMEOUT));
    assign wb_cls    = (cls_q == ClsLoad) ? WbMem : (cls_q == ClsJal) ? WbPc4 : WbAlu;

    // Instruction fields only move in DECODE; inst is a don't-care elsewhere.
    always_comb begin
        cls_d    = cls_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        alufun_d = alufun_q;
        op1sel_d = op1sel_q;
        op2sel_d = op2sel_q;
        if (state_q == StDecode) begin
            cls_d    = dec_cls;
            funct3_d = funct3;
            rd_d     = inst[11:7];
            alufun_d = dec_alufun;
            op1sel_d = dec_op1;
            op2sel_d = dec_op2;
        end
    end

    // The counter only advances while waiting in place, so any exit or mem_ready clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mem_req = 1'b0;
        mem_rw  = 1'b0;
        mem_val = 2'd0;
        ir_wen  = 1'b0;
        pc_wen  = 1'b0;
        rf_wen  = 1'b0;
        pc_sel  = PcPlus4;
        wb_sel  = WbAlu;
        trap    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wen  = 1'b1;
                    state_d = StDecode;
                end else if (timed_out) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StDecode: state_d = dec_legal ? StExec : StTrap;
            StExec: begin
                wb_sel = wb_cls;
                case (cls_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        pc_wen  = 1'b1;
                        pc_sel  = br_taken ? PcBr : PcPlus4;
                        state_d = StFetch;
                    end
                    ClsJal: begin
                        pc_sel  = PcJal;
                        state_d = StWb;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_rw  = (cls_q == ClsStore);
                mem_val = (funct3_q[1:0] == 2'b10) ? 2'd0 : (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd2;
                wb_sel  = wb_cls;
                if (mem_ready) begin
                    if (cls_q == ClsStore) begin
                        pc_wen  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timed_out) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StWb: begin
                rf_wen  = (rd_q != 5'd0);
                pc_wen  = 1'b1;
                pc_sel  = (cls_q == ClsJal) ? PcJal : PcPlus4;
                wb_sel  = wb_cls;
                state_d = StFetch;
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StFetch;
            cnt_q    <= '0;
            cls_q    <= ClsAlu;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            alufun_q <= AluAdd;
            op1sel_q <= Op1Rs1;
            op2sel_q <= Op2Rs2;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cls_q    <= cls_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            alufun_q <= alufun_d;
            op1sel_q <= op1sel_d;
            op2sel_q <= op2sel_d;
        end
    end

    assign state  = state_q;
    assign alufun = alufun_q;
    assign op1sel = op1sel_q;
    assign op2sel = op2sel_q;

endmodule
